// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered clock, 11-bit frame FSM
// with timeout recovery, sticky error flags, and a show-ahead byte FIFO.
module ps2_rx_fifo #(
  parameter int AW         = 3,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000,
  parameter int OVF_MODE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [7:0]    data,
  output logic          valid,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          parity_err,
  output logic          frame_err
);

  localparam int DEPTH = 1 << AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= '1;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_i = rst_pipe[1];

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          filt;
  logic          filt_q;
  logic [FW-1:0] fcnt;
  logic          strobe;
  logic          bit_in;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      clk_s  <= '1;
      dat_s  <= '1;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_data};
      filt_q <= filt;
      if (clk_s[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign strobe = filt_q & ~filt;
  assign bit_in = dat_s[1];

  logic [1:0]    state;
  logic [3:0]    bitcnt;
  logic [9:0]    sr;
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;
  logic          frame_ev;
  logic          parity_ev;
  logic          push;

  assign timeout_hit = (state == SHIFT) && !strobe && (idle_cnt == TW'(TIMEOUT));

  // sr holds D0..D7, parity, stop with D0 at bit 0 once all ten bits are in.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bitcnt   <= '0;
      sr       <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe && !bit_in) begin
            state    <= SHIFT;
            bitcnt   <= 4'd1;
            idle_cnt <= '0;
          end
        end
        SHIFT: begin
          if (strobe) begin
            sr       <= {bit_in, sr[9:1]};
            bitcnt   <= bitcnt + 4'd1;
            idle_cnt <= '0;
            if (bitcnt == 4'd10) state <= CHECK;
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_ev  = ((state == CHECK) && !sr[9]) || timeout_hit;
  assign parity_ev = (state == CHECK) && sr[9] && !(^sr[8:0]);
  assign push      = (state == CHECK) && sr[9] && (^sr[8:0]);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          do_write;
  logic          overflow_ev;

  assign valid       = (level != '0);
  assign full        = (level == (AW + 1)'(DEPTH));
  assign pop         = rd_en & valid;
  assign overflow_ev = push && full && !pop;
  assign do_write    = push && (!full || pop || (OVF_MODE == 1));
  assign data        = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (do_write) mem[wptr] <= sr[7:0];
  end

  // Overwrite mode on a full FIFO advances rptr too, dropping the oldest byte.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_write) wptr <= wptr + 1'b1;
      if (pop || (push && full && (OVF_MODE == 1))) rptr <= rptr + 1'b1;
      if (push && !pop && !full)  level <= level + 1'b1;
      else if (pop && !push)      level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= overflow_ev | (overflow   & ~err_clr);
      parity_err <= parity_ev   | (parity_err & ~err_clr);
      frame_err  <= frame_ev    | (frame_err  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: one drop-mode and one overwrite-mode instance share the
// PS/2 pins and rd_en; expected bytes are queued at send time and checked on each pop.
module tb_ps2_rx_fifo;

  localparam int TO = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd_en = 1'b0;
  logic err_clr = 1'b0;

  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic [3:0] level0, level1;
  logic       ovf0, ovf1, perr0, perr1, ferr0, ferr1;

  ps2_rx_fifo #(.AW(3), .FILTER_LEN(4), .TIMEOUT(TO), .OVF_MODE(0)) u0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .err_clr(err_clr), .data(data0), .valid(valid0), .level(level0), .overflow(ovf0),
    .parity_err(perr0), .frame_err(ferr0));

  ps2_rx_fifo #(.AW(3), .FILTER_LEN(4), .TIMEOUT(TO), .OVF_MODE(1)) u1 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .err_clr(err_clr), .data(data1), .valid(valid1), .level(level1), .overflow(ovf1),
    .parity_err(perr1), .frame_err(ferr1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (rd_en && valid0) begin
      if (q0.size() == 0) check("pop0_unexpected", int'(data0), -1);
      else                check("pop0_data", int'(data0), int'(q0.pop_front()));
    end else if (rd_en && q0.size() != 0) begin
      check("pop0_missing_valid", int'(valid0), 1);
    end
    if (rd_en && valid1) begin
      if (q1.size() == 0) check("pop1_unexpected", int'(data1), -1);
      else                check("pop1_data", int'(data1), int'(q1.pop_front()));
    end else if (rd_en && q1.size() != 0) begin
      check("pop1_missing_valid", int'(valid1), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d);
    q0.push_back(d);
    q1.push_back(d);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  // pulse: 0 none, 1 rd_en, 2 err_clr, timed to coincide with the frame's CHECK cycle.
  task automatic send(input logic [7:0] d, input bit par_flip, input bit stop,
                      input int nbits, input int pulse, input bit glitch);
    logic [10:0] fr;
    fr = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      ps2_data = fr[b];
      tick(5);
      if (glitch && (b == 3 || b == 6)) begin
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(17);
      end else begin
        tick(20);
      end
      ps2_clk = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick(1);
        if (b == 10 && pulse != 0) begin
          if (i == 6) begin
            if (pulse == 1) rd_en = 1'b1;
            else            err_clr = 1'b1;
          end else if (i == 7) begin
            rd_en   = 1'b0;
            err_clr = 1'b0;
          end
        end
      end
      ps2_clk = 1'b1;
      tick(25);
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    tick(5);
    check("rst_valid", int'(valid0), 0);
    check("rst_level", int'(level0), 0);
    rst = 1'b0;
    tick(5);
    check("init_data", int'(data0), 0);
    check("init_flags", int'({ovf0, perr0, ferr0, ovf1, perr1, ferr1}), 0);

    // Basic frame and pop
    push_exp(8'h1C);
    send(8'h1C, 0, 1, 11, 0, 0);
    tick(5);
    check("t1_valid", int'(valid0), 1);
    check("t1_data", int'(data0), 8'h1C);
    check("t1_level", int'(level0), 1);
    pop_one();
    check("t1_valid_after_pop", int'(valid0), 0);
    check("t1_level_after_pop", int'(level0), 0);
    check("t1_data_after_pop", int'(data0), 0);

    // Parity and stop-bit errors
    send(8'h1C, 1, 1, 11, 0, 0);
    check("t2_level", int'(level0), 0);
    check("t2_parity_err", int'(perr0), 1);
    check("t2_frame_err_clean", int'(ferr0), 0);
    clr();
    check("t2_parity_cleared", int'(perr0), 0);
    send(8'h1C, 0, 0, 11, 2, 0);
    check("t2_frame_err_set_wins", int'(ferr0), 1);
    check("t2_parity_clean", int'(perr0), 0);
    check("t2_level_stop", int'(level0), 0);
    clr();
    check("t2_frame_cleared", int'(ferr0), 0);

    // Overflow: drop vs overwrite
    for (int k = 1; k <= 8; k++) begin
      push_exp(8'(k));
      send(8'(k), 0, 1, 11, 0, 0);
    end
    check("t3_full_level", int'(level0), 8);
    check("t3_no_ovf_yet", int'(ovf0), 0);
    send(8'h09, 0, 1, 11, 0, 0);
    void'(q1.pop_front());
    q1.push_back(8'h09);
    check("t3_ovf_m0", int'(ovf0), 1);
    check("t3_ovf_m1", int'(ovf1), 1);
    check("t3_level_m0", int'(level0), 8);
    check("t3_level_m1", int'(level1), 8);
    check("t3_head_m1", int'(data1), 8'h02);
    repeat (8) pop_one();
    check("t3_drained", int'({level0, level1}), 0);
    clr();
    check("t3_ovf_cleared", int'({ovf0, ovf1}), 0);

    // Push coinciding with a pop on a full FIFO
    for (int k = 1; k <= 9; k++) push_exp(8'(k));
    for (int k = 1; k <= 8; k++) send(8'(k), 0, 1, 11, 0, 0);
    send(8'h09, 0, 1, 11, 1, 0);
    check("t3s_ovf_m0", int'(ovf0), 0);
    check("t3s_ovf_m1", int'(ovf1), 0);
    check("t3s_level_m0", int'(level0), 8);
    check("t3s_head_m0", int'(data0), 8'h02);
    repeat (8) pop_one();
    check("t3s_drained", int'(level0), 0);

    // Sub-threshold glitches on ps2_clk
    push_exp(8'hF0);
    send(8'hF0, 0, 1, 11, 0, 1);
    check("t4_level", int'(level0), 1);
    check("t4_data", int'(data0), 8'hF0);
    check("t4_errs", int'({perr0, ferr0}), 0);
    pop_one();

    // Timeout abort of a partial frame
    send(8'hA5, 0, 1, 5, 0, 0);
    tick(TO + 10);
    check("t5_frame_err", int'(ferr0), 1);
    check("t5_level", int'(level0), 0);
    push_exp(8'h5A);
    send(8'h5A, 0, 1, 11, 0, 0);
    check("t5_data", int'(data0), 8'h5A);
    check("t5_level_after", int'(level0), 1);

    // Reset mid-frame
    send(8'h29, 0, 1, 6, 0, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", int'({valid0, valid1}), 0);
    check("t6_rst_data", int'(data0), 0);
    check("t6_rst_level", int'(level0), 0);
    check("t6_rst_flags", int'({ferr0, perr0, ovf0}), 0);
    q0.delete();
    q1.delete();
    tick(3);
    rst = 1'b0;
    tick(10);
    push_exp(8'h29);
    send(8'h29, 0, 1, 11, 0, 0);
    check("t6_data", int'(data0), 8'h29);
    check("t6_level", int'(level0), 1);
    pop_one();
    check("t6_level_after_pop", int'(level0), 0);

    tick(2);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
